data_mem_responder: RTL and testbench

- Memory-side responder for the controller sequencer's data-memory handshake.
- Accepts read and write requests addressed by MAR and performs them after a programmable wait.
- Raises `dataReady` and holds it until the controller drops the request (four-phase handshake).
- Also services the controller's `DRAMclr` by sweeping the whole array to zero. Sits between the datapath (MAR/ACC) and the data RAM array.

---
 rtl/data_mem_responder.sv | 118 +++++++++++
 tb/tb_data_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: four-phase memReq/dataReady handshake with a programmable
// access wait, plus a whole-array zero sweep on clr.
module data_mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memReq,
  input  logic              writeEnable,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              dataReady,
  output logic              busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = (WAIT_CYC < 2) ? 1 : $clog2(WAIT_CYC + 1);
  localparam logic [CntW-1:0]   CntLoad  = CntW'(WAIT_CYC);
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StReady, StClear} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem [Depth];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;

    unique case (state_q)
      StIdle: begin
        // clr has priority; a request held across the sweep is served afterwards
        if (clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end else if (memReq) begin
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = writeEnable;
          cnt_d   = CntLoad;
          state_d = (WAIT_CYC > 0) ? StWait : StAccess;
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) state_d = StAccess;
      end
      StAccess: begin
        if (we_q) mem_we = 1'b1;
        else      rdata_d = mem[addr_q];
        state_d = StReady;
      end
      StReady: begin
        if (!memReq) state_d = StIdle;
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LastAddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never reset, but a reset edge must still suppress a pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  assign rdata     = rdata_q;
  assign dataReady = (state_q == StReady);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a WAIT_CYC=2 instance and a WAIT_CYC=0 instance.
module tb_data_mem_responder;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int WAIT = 2;

  typedef struct {
    int            exp_cyc;
    bit            chk_data;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          memReq, writeEnable, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic          dataReady, busy;

  logic          b_memReq, b_we, b_clr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          b_dataReady, b_busy;

  data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WAIT)) dut (
    .clk(clk), .rst(rst), .memReq(memReq), .writeEnable(writeEnable), .clr(clr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .dataReady(dataReady), .busy(busy)
  );

  data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .memReq(b_memReq), .writeEnable(b_we), .clr(b_clr),
    .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .dataReady(b_dataReady), .busy(b_busy)
  );

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q2[$];
  exp_t q0[$];
  exp_t m2, m0;
  logic dr_prev2 = 1'b0;
  logic dr_prev0 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: each rising dataReady pops one expected response per instance.
  always @(negedge clk) begin
    if (dataReady && !dr_prev2) begin
      if (q2.size() == 0) check("spurious_ready_w2", 32'd1, 32'd0);
      else begin
        m2 = q2.pop_front();
        if (m2.exp_cyc >= 0) check("latency_w2", 32'(cyc), 32'(m2.exp_cyc));
        if (m2.chk_data) check("rdata_w2", 32'(rdata), 32'(m2.data));
      end
    end
    if (b_dataReady && !dr_prev0) begin
      if (q0.size() == 0) check("spurious_ready_w0", 32'd1, 32'd0);
      else begin
        m0 = q0.pop_front();
        if (m0.exp_cyc >= 0) check("latency_w0", 32'(cyc), 32'(m0.exp_cyc));
        if (m0.chk_data) check("rdata_w0", 32'(b_rdata), 32'(m0.data));
      end
    end
    dr_prev2 <= dataReady;
    dr_prev0 <= b_dataReady;
  end

  task automatic drive(input bit z, input bit rq, input bit we, input bit c,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (z) begin
      b_memReq = rq; b_we = we; b_clr = c; b_addr = a; b_wdata = d;
    end else begin
      memReq = rq; writeEnable = we; clr = c; addr = a; wdata = d;
    end
  endtask

  function automatic logic dr(input bit z);
    return z ? b_dataReady : dataReady;
  endfunction

  function automatic logic [DW-1:0] rd(input bit z);
    return z ? b_rdata : rdata;
  endfunction

  task automatic wait_dr(input bit z, input int lim);
    int n = 0;
    while (dr(z) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (dr(z) !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // One full handshake; inputs are scrambled right after latching.
  task automatic access(input bit z, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp, input int hold);
    exp_t e;
    @(negedge clk);
    drive(z, 1'b1, we, 1'b0, a, d);
    e.exp_cyc  = cyc + (z ? 0 : WAIT) + 2;
    e.chk_data = !we;
    e.data     = exp;
    if (z) q0.push_back(e);
    else   q2.push_back(e);
    @(negedge clk);
    drive(z, 1'b1, !we, 1'b0, ~a, ~d);
    wait_dr(z, 400);
    repeat (hold) begin
      @(negedge clk);
      check("hold_ready", 32'(dr(z)), 32'd1);
      if (!we) check("hold_rdata", 32'(rd(z)), 32'(exp));
    end
    drive(z, 1'b0, 1'b0, 1'b0, ~a, ~d);
    @(negedge clk);
    check("ready_drop", 32'(dr(z)), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(dataReady), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    check("reset_w0_busy", 32'(b_busy), 32'd0);

    // Write, read back with a 10-cycle hold, then a write must not disturb rdata.
    access(1'b0, 1'b1, 8'h05, 16'hBEEF, 16'h0000, 0);
    access(1'b0, 1'b0, 8'h05, 16'h0000, 16'hBEEF, 10);
    access(1'b0, 1'b1, 8'h06, 16'h7777, 16'h0000, 0);
    check("rdata_kept_after_write", 32'(rdata), 32'hBEEF);
    access(1'b0, 1'b0, 8'h06, 16'h0000, 16'h7777, 0);

    // Whole-array clear.
    access(1'b0, 1'b1, 8'h00, 16'h1234, 16'h0000, 0);
    access(1'b0, 1'b1, 8'hFF, 16'hFFFF, 16'h0000, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("clear_busy_cycles", 32'(n), 32'd256);
    access(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 0);
    access(1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0000, 0);

    // clr and memReq together: sweep first, then the held read returns zero.
    access(1'b0, 1'b1, 8'h10, 16'h00AA, 16'h0000, 0);
    access(1'b0, 1'b0, 8'h10, 16'h0000, 16'h00AA, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0000);
    e.exp_cyc = -1; e.chk_data = 1'b1; e.data = 16'h0000;
    q2.push_back(e);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 16'h0000);
    check("clear_busy_start", 32'(busy), 32'd1);
    wait_dr(1'b0, 600);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
    @(negedge clk);
    check("ready_drop_after_clear", 32'(dataReady), 32'd0);

    // Reset during the WAIT of a write aborts it.
    access(1'b0, 1'b1, 8'h20, 16'h1111, 16'h0000, 0);
    access(1'b0, 1'b0, 8'h20, 16'h0000, 16'h1111, 0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, 16'h5555);
    @(negedge clk);
    check("busy_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 16'h5555);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(dataReady), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    access(1'b0, 1'b0, 8'h20, 16'h0000, 16'h1111, 0);

    // WAIT_CYC=0 instance: two-cycle latency, latched address used.
    access(1'b1, 1'b1, 8'h33, 16'h0A5A, 16'h0000, 0);
    access(1'b1, 1'b1, 8'h34, 16'h0001, 16'h0000, 0);
    access(1'b1, 1'b0, 8'h33, 16'h0000, 16'h0A5A, 2);
    access(1'b1, 1'b0, 8'h34, 16'h0000, 16'h0001, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(q2.size() + q0.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
